// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase sequencer.
package traffic_pkg;

  typedef enum logic [3:0] {
    ST_STARTUP = 4'd0,
    ST_TURN_G  = 4'd1,
    ST_TURN_Y  = 4'd2,
    ST_TURN_R  = 4'd3,
    ST_THRU_G  = 4'd4,
    ST_THRU_Y  = 4'd5,
    ST_THRU_R  = 4'd6,
    ST_FLASH   = 4'd7
  } state_e;

  localparam logic [1:0] LAMP_OFF = 2'b00;
  localparam logic [1:0] LAMP_RED = 2'b01;
  localparam logic [1:0] LAMP_YEL = 2'b10;
  localparam logic [1:0] LAMP_GRN = 2'b11;

  // Green length in ticks for a given flow step; caller narrows to the timer width.
  function automatic logic [63:0] green_ticks(input logic [63:0] base,
                                              input logic [63:0] step,
                                              input logic [1:0]  flow);
    return base + ({62'd0, flow} * step);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero flag is combinational from the count.
module phase_timer #(
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             slowclk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset)             cnt <= RST_VAL;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Round-robin turn/through phase sequencer with pedestrian walk, permissive
// flashing-yellow turn and all-red flash mode. Lamps are Moore-decoded.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter  int NUM_AXES     = 2,
  parameter  int CNT_W        = 26,
  parameter  int GREEN_BASE   = 23437500,
  parameter  int GREEN_STEP   = 7812500,
  parameter  int YELLOW_TICKS = 9375000,
  parameter  int RED_TICKS    = 6250000,
  parameter  int FLASH_TICKS  = 3125000,
  localparam int AX_W         = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1
) (
  input  logic                  slowclk,
  input  logic                  reset,
  input  logic [1:0]            flow,
  input  logic [NUM_AXES-1:0]   ped_req,
  input  logic                  flash_mode,
  output logic [AX_W-1:0]       active_axis,
  output logic [2*NUM_AXES-1:0] turn_lamp,
  output logic [2*NUM_AXES-1:0] thru_lamp,
  output logic [NUM_AXES-1:0]   walk,
  output logic [NUM_AXES-1:0]   ped_pending,
  output logic [3:0]            state_code
);

  localparam logic [63:0] CNT_LIM = 64'd1 << CNT_W;
  localparam logic [63:0] GMAX    = 64'(GREEN_BASE) + 64'd3 * 64'(GREEN_STEP);

  if (NUM_AXES < 2 || NUM_AXES > 8) begin : g_bad_axes
    $error("NUM_AXES must be 2..8");
  end
  if (GREEN_BASE < 1 || YELLOW_TICKS < 1 || RED_TICKS < 1 || FLASH_TICKS < 1 ||
      GREEN_STEP < 0) begin : g_bad_dur
    $error("every duration must be at least 1");
  end
  if (GMAX >= CNT_LIM || 64'(YELLOW_TICKS) >= CNT_LIM || 64'(RED_TICKS) >= CNT_LIM ||
      64'(FLASH_TICKS) >= CNT_LIM) begin : g_bad_width
    $error("durations do not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LD   = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_TICKS - 1);

  state_e                        state, state_n;
  logic [AX_W-1:0]               axis, axis_n, axis_inc;
  logic                          walk_flag, walk_flag_n;
  logic                          flash_phase;
  logic [NUM_AXES-1:0]           clr_mask;
  logic                          tmr_load, tmr_zero;
  logic [CNT_W-1:0]              tmr_val, green_ld;
  logic                          fl_enter, fl_zero;
  logic [NUM_AXES-1:0][1:0]      turn_a, thru_a;

  assign green_ld = CNT_W'(green_ticks(64'(GREEN_BASE), 64'(GREEN_STEP), flow) - 64'd1);
  assign axis_inc = (axis == AX_W'(NUM_AXES - 1)) ? '0 : axis + 1'b1;

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(RED_LD)) u_phase_tmr (
    .slowclk (slowclk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // Half-period timer for the permissive-turn and all-red flashing.
  phase_timer #(.CNT_W(CNT_W), .RST_VAL(FLASH_LD)) u_flash_tmr (
    .slowclk (slowclk),
    .reset   (reset),
    .load    (fl_enter | fl_zero),
    .load_val(FLASH_LD),
    .zero    (fl_zero)
  );

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      state       <= ST_STARTUP;
      axis        <= '0;
      walk_flag   <= 1'b0;
      flash_phase <= 1'b0;
      ped_pending <= '0;
    end else begin
      state       <= state_n;
      axis        <= axis_n;
      walk_flag   <= walk_flag_n;
      ped_pending <= (ped_pending & ~clr_mask) | ped_req;
      if (fl_enter)     flash_phase <= 1'b0;
      else if (fl_zero) flash_phase <= ~flash_phase;
    end
  end

  always_comb begin
    state_n     = state;
    axis_n      = axis;
    walk_flag_n = walk_flag;
    tmr_load    = 1'b0;
    tmr_val     = RED_LD;
    clr_mask    = '0;
    case (state)
      ST_STARTUP: if (tmr_zero) begin
        if (flash_mode) state_n = ST_FLASH;
        else begin
          state_n  = ST_TURN_G;
          tmr_load = 1'b1;
          tmr_val  = green_ld;
        end
      end
      ST_TURN_G: if (tmr_zero) begin
        state_n  = ST_TURN_Y;
        tmr_load = 1'b1;
        tmr_val  = YEL_LD;
      end
      ST_TURN_Y: if (tmr_zero) begin
        state_n  = ST_TURN_R;
        tmr_load = 1'b1;
      end
      ST_TURN_R: if (tmr_zero) begin
        if (flash_mode) state_n = ST_FLASH;
        else begin
          state_n          = ST_THRU_G;
          tmr_load         = 1'b1;
          tmr_val          = green_ld;
          walk_flag_n      = ped_pending[axis];
          clr_mask[axis]   = 1'b1;
        end
      end
      ST_THRU_G: if (tmr_zero) begin
        state_n  = ST_THRU_Y;
        tmr_load = 1'b1;
        tmr_val  = YEL_LD;
      end
      ST_THRU_Y: if (tmr_zero) begin
        state_n  = ST_THRU_R;
        tmr_load = 1'b1;
      end
      ST_THRU_R: if (tmr_zero) begin
        if (flash_mode) state_n = ST_FLASH;
        else begin
          state_n  = ST_TURN_G;
          axis_n   = axis_inc;
          tmr_load = 1'b1;
          tmr_val  = green_ld;
        end
      end
      ST_FLASH: if (!flash_mode) begin
        state_n  = ST_STARTUP;
        axis_n   = '0;
        tmr_load = 1'b1;
      end
      default: state_n = ST_STARTUP;
    endcase
  end

  assign fl_enter = (state_n != state) && (state_n == ST_THRU_G || state_n == ST_FLASH);

  // Returns {turn, thru} for one axis.
  function automatic logic [3:0] lane_lamps(input state_e st, input logic act,
                                            input logic wf, input logic ph);
    logic [1:0] t, h;
    t = LAMP_RED;
    h = LAMP_RED;
    if (st == ST_FLASH) begin
      t = ph ? LAMP_OFF : LAMP_RED;
      h = t;
    end else if (act) begin
      case (st)
        ST_TURN_G: t = LAMP_GRN;
        ST_TURN_Y: t = LAMP_YEL;
        ST_THRU_G: begin
          h = LAMP_GRN;
          t = wf ? LAMP_RED : (ph ? LAMP_OFF : LAMP_YEL);
        end
        ST_THRU_Y: h = LAMP_YEL;
        default: ;
      endcase
    end
    return {t, h};
  endfunction

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_lane
    logic act;
    assign act = (axis == AX_W'(i));
    assign {turn_a[i], thru_a[i]} = lane_lamps(state, act, walk_flag, flash_phase);
    assign walk[i] = (state == ST_THRU_G) && act && walk_flag;
  end

  assign turn_lamp   = turn_a;
  assign thru_lamp   = thru_a;
  assign active_axis = axis;
  assign state_code  = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: a phase-list reference model queues the expected outputs
// after every edge, a negedge monitor pops and compares.
module tb_traffic_phase_sequencer;

  localparam int N = 2, CW = 8, GB = 8, GS = 4, YT = 3, RT = 2, FT = 2;

  logic             slowclk = 1'b0;
  logic             reset;
  logic [1:0]       flow;
  logic [N-1:0]     ped_req;
  logic             flash_mode;
  logic [0:0]       active_axis;
  logic [2*N-1:0]   turn_lamp, thru_lamp;
  logic [N-1:0]     walk, ped_pending;
  logic [3:0]       state_code;

  traffic_phase_sequencer #(
    .NUM_AXES(N), .CNT_W(CW), .GREEN_BASE(GB), .GREEN_STEP(GS),
    .YELLOW_TICKS(YT), .RED_TICKS(RT), .FLASH_TICKS(FT)
  ) dut (
    .slowclk(slowclk), .reset(reset), .flow(flow), .ped_req(ped_req),
    .flash_mode(flash_mode), .active_axis(active_axis), .turn_lamp(turn_lamp),
    .thru_lamp(thru_lamp), .walk(walk), .ped_pending(ped_pending),
    .state_code(state_code)
  );

  always #5 slowclk = ~slowclk;

  typedef struct {
    int         st;
    int         ax;
    logic [3:0] turn;
    logic [3:0] thru;
    logic [1:0] wlk;
    logic [1:0] pend;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0, n_fail = 0;

  // Phase numbering: 0 startup, 1 turn G, 2 turn Y, 3 turn R,
  // 4 thru G, 5 thru Y, 6 thru R, 7 flash.
  int         m_ph, m_left, m_el, m_ax;
  bit         m_wf;
  logic [1:0] m_pend;

  function automatic int dur_of(int ph, int fl);
    if (ph == 1 || ph == 4) return GB + fl * GS;
    if (ph == 2 || ph == 5) return YT;
    return RT;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_left = RT; m_el = 0; m_ax = 0; m_wf = 0; m_pend = '0;
  endtask

  task automatic model_step();
    int nph, nax;
    logic [1:0] clr;
    nph = m_ph; nax = m_ax; clr = '0;
    if (m_ph == 7) begin
      if (!flash_mode) begin nph = 0; nax = 0; end
    end else if (m_left == 1) begin
      case (m_ph)
        0: nph = flash_mode ? 7 : 1;
        1: nph = 2;
        2: nph = 3;
        3: if (flash_mode) nph = 7;
           else begin nph = 4; m_wf = m_pend[m_ax]; clr[m_ax] = 1'b1; end
        4: nph = 5;
        5: nph = 6;
        default: if (flash_mode) nph = 7;
                 else begin nph = 1; nax = (m_ax + 1) % N; end
      endcase
    end
    m_pend = (m_pend & ~clr) | ped_req;
    if (nph != m_ph) begin
      m_ph = nph; m_ax = nax; m_el = 0; m_left = dur_of(nph, int'(flow));
    end else begin
      m_el++; m_left--;
    end
  endtask

  function automatic exp_t mk_exp();
    exp_t e;
    bit   odd;
    e.st = m_ph; e.ax = m_ax; e.pend = m_pend; e.wlk = '0;
    odd = ((m_el / FT) % 2) == 1;
    for (int a = 0; a < N; a++) begin
      logic [1:0] t, h;
      t = 2'b01; h = 2'b01;
      if (m_ph == 7) begin
        t = odd ? 2'b00 : 2'b01; h = t;
      end else if (a == m_ax) begin
        if (m_ph == 1) t = 2'b11;
        if (m_ph == 2) t = 2'b10;
        if (m_ph == 4) begin
          h = 2'b11;
          t = m_wf ? 2'b01 : (odd ? 2'b00 : 2'b10);
          e.wlk[a] = m_wf;
        end
        if (m_ph == 5) h = 2'b10;
      end
      e.turn[2*a +: 2] = t;
      e.thru[2*a +: 2] = h;
    end
    return e;
  endfunction

  // Reference model: advances on each edge, reset event replaces pending expectations.
  initial begin
    forever begin
      @(posedge slowclk or posedge reset);
      if (reset) begin
        model_reset();
        expq.delete();
      end else begin
        model_step();
      end
      expq.push_back(mk_exp());
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge slowclk);
      if (expq.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("state_code", 32'(state_code), 32'(e.st));
        if (e.st != 7) chk("active_axis", 32'(active_axis), 32'(e.ax));
        chk("turn_lamp", 32'(turn_lamp), 32'(e.turn));
        chk("thru_lamp", 32'(thru_lamp), 32'(e.thru));
        chk("walk", 32'(walk), 32'(e.wlk));
        chk("ped_pending", 32'(ped_pending), 32'(e.pend));
      end
    end
  end

  task automatic tick();
    @(posedge slowclk);
    #2;
  endtask

  task automatic rand_cycles(input int n);
    int fl_left = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if ($urandom_range(0, 9) == 0) flow = 2'($urandom_range(0, 3));
      ped_req = ($urandom_range(0, 11) == 0) ? N'($urandom_range(1, 3)) : '0;
      if (fl_left > 0) begin
        fl_left--;
        if (fl_left == 0) flash_mode = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        flash_mode = 1'b1;
        fl_left = $urandom_range(3, 60);
      end
    end
    flash_mode = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flow = 2'd0; ped_req = '0; flash_mode = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge slowclk);
    #2 reset = 1'b0;

    // Quiet run: two full axis rounds at flow 0.
    repeat (110) tick();

    // Long green, then drop flow mid-green.
    flow = 2'd3;
    repeat (40) tick();
    flow = 2'd0;
    repeat (30) tick();

    // Single-cycle pedestrian pulse for axis 1 while axis 0 turns.
    for (int k = 0; k < 200 && !(m_ph == 1 && m_ax == 0); k++) tick();
    ped_req = 2'b10;
    tick();
    ped_req = '0;
    repeat (80) tick();

    // Flash request raised during a turn green.
    for (int k = 0; k < 200 && m_ph != 1; k++) tick();
    flash_mode = 1'b1;
    repeat (40) tick();
    flash_mode = 1'b0;
    repeat (20) tick();

    rand_cycles(2500);

    // Reset mid thru-yellow with both requests latched.
    for (int k = 0; k < 300 && m_ph != 5; k++) tick();
    if (m_ph != 5) chk("wait_thru_y", 32'(m_ph), 32'd5);
    ped_req = 2'b11;
    tick();
    ped_req = '0;
    reset   = 1'b1;
    repeat (2) tick();
    reset   = 1'b0;

    rand_cycles(300);
    repeat (2) @(negedge slowclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
